// File: rtl/sig_pkg.sv
// Shared definitions for the sample-ring delay path: default RAM geometry and
// the delay-controller state type.
package sig_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 9;
    localparam int DEFAULT_DATA_WIDTH    = 8;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dly_state_t;

endpackage

// File: rtl/ring_ptr.sv
// Wrapping ring pointers for the delay line: the sample write pointer, the
// clear sweep counter, and the read address trailing the writer by delay_i.
module ring_ptr #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          wr_inc_i,
    input  logic          clr_inc_i,
    input  logic [AW-1:0] delay_i,
    output logic [AW-1:0] wr_ptr_o,
    output logic [AW-1:0] clr_cnt_o,
    output logic [AW-1:0] rd_addr_o
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    // clr_i wins over both increments so a restart always begins at address 0.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        clr_cnt_d = clr_cnt_q;
        if (clr_i) begin
            wr_ptr_d  = '0;
            clr_cnt_d = '0;
        end else begin
            if (wr_inc_i)  wr_ptr_d  = wr_ptr_q + AW'(1);
            if (clr_inc_i) clr_cnt_d = clr_cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            clr_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign wr_ptr_o  = wr_ptr_q;
    assign clr_cnt_o = clr_cnt_q;
    assign rd_addr_o = wr_ptr_q - delay_i;

endmodule

// File: rtl/sig_delay_ctrl.sv
// Circular delay-line controller: sweeps the sample RAM to zero, then writes each
// accepted sample and returns the one written `delay` samples earlier, 2 cycles later.
module sig_delay_ctrl
    import sig_pkg::*;
#(
    parameter int ADDRESS_WIDTH = sig_pkg::DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = sig_pkg::DEFAULT_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [ADDRESS_WIDTH-1:0] delay,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     ram_wr_en,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    output logic                     ram_rd_en,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]    ram_dout,
    output dly_state_t               dbg_state
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;

    dly_state_t state_q, state_d;

    logic          accept;
    logic          clear_wr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] rd_addr;

    logic          s1_valid_q;
    logic          s1_byp_q;
    logic [DW-1:0] s1_data_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;

    // Handshake: a sample transfers on a cycle where in_valid && in_ready; in_ready
    // never depends on in_valid. The output side has no ready and cannot stall.
    // rst_n gates the combinational outputs so they read 0 throughout reset.
    assign in_ready = rst_n & (state_q == RUN) & ~clr;
    assign accept   = in_ready & in_valid;
    assign clear_wr = rst_n & (state_q == CLEAR);

    ring_ptr #(.AW(AW)) u_ring_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .wr_inc_i  (accept),
        .clr_inc_i (state_q == CLEAR),
        .delay_i   (delay),
        .wr_ptr_o  (wr_ptr),
        .clr_cnt_o (clr_cnt),
        .rd_addr_o (rd_addr)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   if (!clr && (&clr_cnt)) state_d = RUN;
            RUN:     if (clr) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CLEAR;
        else        state_q <= state_d;
    end

    assign ram_wr_en   = clear_wr | accept;
    assign ram_wr_addr = clear_wr ? clr_cnt : (accept ? wr_ptr : '0);
    assign ram_din     = accept ? in_data : '0;
    assign ram_rd_en   = accept;
    assign ram_rd_addr = accept ? rd_addr : '0;

    // With delay 0 the RAM returns the pre-write contents, so the sample itself
    // is carried alongside and selected in place of ram_dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_byp_q    <= 1'b0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            s1_valid_q  <= accept;
            out_valid_q <= s1_valid_q;
            if (accept) begin
                s1_byp_q  <= (delay == '0);
                s1_data_q <= in_data;
            end
            if (s1_valid_q) begin
                out_data_q <= s1_byp_q ? s1_data_q : ram_dout;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sig_delay_ctrl.sv
// Directed bench for sig_delay_ctrl with a behavioural read-before-write RAM beside it.
module tb_sig_delay_ctrl;
    import sig_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [8:0] delay;
    logic       out_valid;
    logic [7:0] out_data;
    logic       ram_wr_en;
    logic [8:0] ram_wr_addr;
    logic [7:0] ram_din;
    logic       ram_rd_en;
    logic [8:0] ram_rd_addr;
    logic [7:0] ram_dout;
    dly_state_t dbg_state;

    logic [7:0] mem [512];
    logic [7:0] stim_q[$];
    logic [7:0] exp_q[$];

    int checks;
    int failures;

    sig_delay_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .delay       (delay),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_din     (ram_din),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_dout    (ram_dout),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample RAM: registered read, old data on a same-address read/write
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
        if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Check clear-sweep cycles writing addresses first..last
    task automatic clear_seq(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            check("clr_wr_en", ram_wr_en, 1);
            check("clr_wr_addr", ram_wr_addr, i);
            check("clr_din", ram_din, 0);
            check("clr_in_ready", in_ready, 0);
            check("clr_rd_en", ram_rd_en, 0);
            tick();
        end
    endtask

    // Feed stim_q back-to-back from write pointer ptr0; check RAM controls and
    // the outputs against exp_q at 2-cycle latency. clr_end raises clr together
    // with in_valid on the cycle after the last sample.
    task automatic stream(input int n, input int d, input int ptr0, input bit clr_end);
        for (int c = 0; c < n + 3; c++) begin
            in_valid = 1'b0;
            clr      = 1'b0;
            delay    = 9'(d);
            if (c < n) begin
                in_valid = 1'b1;
                in_data  = stim_q[c];
            end else if (c == n && clr_end) begin
                in_valid = 1'b1;
                in_data  = 8'hEE;
                clr      = 1'b1;
            end
            #1;
            if (c < n) begin
                check("in_ready", in_ready, 1);
                check("wr_en", ram_wr_en, 1);
                check("wr_addr", ram_wr_addr, (ptr0 + c) % 512);
                check("din", ram_din, stim_q[c]);
                check("rd_en", ram_rd_en, 1);
                check("rd_addr", ram_rd_addr, (ptr0 + c + 512 - d) % 512);
            end else if (c == n) begin
                check("idle_in_ready", in_ready, clr_end ? 0 : 1);
                check("idle_wr_en", ram_wr_en, 0);
                check("idle_rd_en", ram_rd_en, 0);
            end
            if (c >= 2 && c - 2 < n) begin
                check("out_valid", out_valid, 1);
                check("out_data", out_data, exp_q[c-2]);
            end else begin
                check("out_valid_idle", out_valid, 0);
            end
            tick();
        end
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        delay    = 9'd0;

        // Reset state
        tick();
        tick();
        check("rst_wr_en", ram_wr_en, 0);
        check("rst_wr_addr", ram_wr_addr, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_state", dbg_state, CLEAR);

        // 1: clear sweep after reset release
        rst_n = 1'b1;
        #1;
        clear_seq(0, 511);
        check("run_in_ready", in_ready, 1);
        check("run_state", dbg_state, RUN);
        check("run_wr_en", ram_wr_en, 0);

        // 2: delay 3, samples 1..5
        stim_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        exp_q  = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
        stream(5, 3, 0, 1'b0);

        // 3: delay 0 bypass
        stim_q = '{8'hA5, 8'h3C};
        exp_q  = '{8'hA5, 8'h3C};
        stream(2, 0, 5, 1'b0);
        check("hold_out_data", out_data, 8'h3C);

        // Fresh ring for the long test
        clr = 1'b1;
        #1;
        check("clr_in_ready", in_ready, 0);
        tick();
        clr = 1'b0;
        #1;
        clear_seq(0, 511);
        check("ptr_reset_ready", in_ready, 1);

        // 4: delay 511, 600 incrementing samples with write-address wrap
        stim_q.delete();
        exp_q.delete();
        for (int n = 0; n < 600; n++) begin
            stim_q.push_back(8'(n));
            exp_q.push_back(n < 511 ? 8'd0 : 8'(n - 511));
        end
        stream(600, 511, 0, 1'b0);

        // 5: delay 2, 10 samples, then clr with a coincident in_valid
        stim_q.delete();
        exp_q.delete();
        exp_q.push_back(8'd86);
        exp_q.push_back(8'd87);
        for (int i = 0; i < 10; i++) stim_q.push_back(8'(8'h40 + i));
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(8'h40 + i));
        stream(10, 2, 88, 1'b1);
        check("clr5_state", dbg_state, CLEAR);
        clear_seq(2, 511);
        check("clr5_ready", in_ready, 1);
        stim_q = '{8'h5A};
        exp_q  = '{8'h5A};
        stream(1, 0, 0, 1'b0);

        // 6: reset during clear cycle 100
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        clear_seq(0, 99);
        check("pre_rst_addr", ram_wr_addr, 100);
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", ram_wr_en, 0);
        check("midrst_wr_addr", ram_wr_addr, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        clear_seq(0, 511);
        check("final_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
